// File: rtl/cyq_cnt_pkg.sv
// Shared definitions for the modulus up/down counter family.
// Holds the direction encoding, a constant clog2 and the parameter legality macro.
`define CYQ_CNT_LEGAL(W, M) (((W) >= 2) && ((W) <= 16) && ((M) >= 2) && (cyq_cnt_pkg::clog2(M) <= (W)))

package cyq_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cyq_cnt_next.sv
// Next-state logic for the modulus counter: load, up/down step with wrap, or hold.
// Purely combinational; the wrap output marks a modulus rollover in either direction.
module cyq_cnt_next
  import cyq_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             Up,
  input  logic [WIDTH-1:0] D,
  input  logic             PE,
  input  logic             en,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  logic [WIDTH:0] q_x;
  logic           out_of_range;

  // Extra bit keeps the compare legal when MODULUS equals 2**WIDTH.
  assign q_x          = {1'b0, Q};
  assign out_of_range = (q_x >= MOD_X);

  always_comb begin
    next_q = Q;
    wrap   = 1'b0;
    if (!PE) begin
      next_q = D;
    end else if (en) begin
      if (Up == CNT_UP) begin
        if (Q >= MAX_Q) begin
          next_q = '0;
          wrap   = 1'b1;
        end else begin
          next_q = Q + WIDTH'(1);
        end
      end else begin
        if ((Q == '0) || out_of_range) begin
          next_q = MAX_Q;
          wrap   = 1'b1;
        end else begin
          next_q = Q - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cyq_counter_mod_updn.sv
// Parametrised up/down modulus counter with 161-style Cep/Cet/PE controls.
// Registers Q and the one-cycle wrap pulse CO; TC is the combinational cascade output.
module cyq_counter_mod_updn
  import cyq_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             MR,
  input  logic             Cep,
  input  logic             Cet,
  input  logic             PE,
  input  logic             Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  if (!`CYQ_CNT_LEGAL(WIDTH, MODULUS)) begin : g_bad_param
    $error("cyq_counter_mod_updn: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] next_q;
  logic             wrap;

  cyq_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .Q      (cnt_q),
    .Up     (Up),
    .D      (D),
    .PE     (PE),
    .en     (Cep & Cet),
    .next_q (next_q),
    .wrap   (wrap)
  );

  always_comb begin
    cnt_d = next_q;
    co_d  = wrap;
  end

  // MR beats load and count; CO clears on any edge that does not wrap.
  always_ff @(posedge clk) begin
    if (MR) begin
      cnt_q <= '0;
      co_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      co_q  <= co_d;
    end
  end

  assign Q  = cnt_q;
  assign CO = co_q;
  assign TC = Cet & ((Up == CNT_UP) ? (cnt_q == MAX_Q) : (cnt_q == '0));

endmodule

// File: tb/tb_cyq_counter_mod_updn.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model,
// and an 8-bit two-stage cascade.
module tb_cyq_counter_mod_updn;

  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         mr, cep, cet, pe, up;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc, co;

  logic       c_mr, c_cep, c_cet, c_pe, c_up;
  logic [7:0] c_d;
  logic [7:0] q0, q1;
  logic       tc0, tc1, co0, co1;

  cyq_counter_mod_updn #(.WIDTH(W), .MODULUS(M)) dut (
    .clk (clk), .MR (mr), .Cep (cep), .Cet (cet), .PE (pe), .Up (up),
    .D (d), .Q (q), .TC (tc), .CO (co)
  );

  cyq_counter_mod_updn #(.WIDTH(8), .MODULUS(256)) stage0 (
    .clk (clk), .MR (c_mr), .Cep (c_cep), .Cet (c_cet), .PE (c_pe), .Up (c_up),
    .D (c_d), .Q (q0), .TC (tc0), .CO (co0)
  );

  cyq_counter_mod_updn #(.WIDTH(8), .MODULUS(256)) stage1 (
    .clk (clk), .MR (c_mr), .Cep (c_cep), .Cet (tc0), .PE (c_pe), .Up (c_up),
    .D (c_d), .Q (q1), .TC (tc1), .CO (co1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for the 4-bit modulus-10 instance.
  int m_q  = 0;
  int m_co = 0;

  function automatic int exp_tc();
    if (!cet) return 0;
    if (up) return (m_q == M - 1) ? 1 : 0;
    return (m_q == 0) ? 1 : 0;
  endfunction

  // Advance one clock; the model sees the same inputs the DUT samples at that edge.
  task automatic tick();
    @(posedge clk);
    if (mr) begin
      m_q  = 0;
      m_co = 0;
    end else if (!pe) begin
      m_q  = int'(d);
      m_co = 0;
    end else if (cep && cet) begin
      if (up) begin
        m_q  = (m_q < M) ? (m_q + 1) % M : 0;
        m_co = (m_q == 0) ? 1 : 0;
      end else begin
        m_q  = (m_q > 0 && m_q < M) ? m_q - 1 : M - 1;
        m_co = (m_q == M - 1) ? 1 : 0;
      end
    end else begin
      m_co = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    mr = 1'b1; pe = 1'b0; d = 4'd7; cep = 1'b1; cet = 1'b1; up = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++;
    if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %0b want 0", co); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %0b want 1", tc); end
    up = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %0b want 0", tc); end
  endtask

  task automatic test_count(input logic dir);
    mr = 1'b1; pe = 1'b1; cep = 1'b1; cet = 1'b1; up = dir;
    tick();
    mr = 1'b0;
    for (int i = 0; i < 2 * M + 3; i++) begin
      tick();
      checks++;
      if (q !== W'(m_q)) begin errors++; $display("FAIL count_q dir=%0b step %0d: got %0d want %0d", dir, i, q, m_q); end
      checks++;
      if (co !== m_co[0]) begin errors++; $display("FAIL count_co dir=%0b step %0d: got %0b want %0d", dir, i, co, m_co); end
      checks++;
      if (tc !== exp_tc()) begin errors++; $display("FAIL count_tc dir=%0b step %0d: got %0b want %0d", dir, i, tc, exp_tc()); end
    end
  endtask

  task automatic test_out_of_range();
    pe = 1'b0; d = 4'hC; cep = 1'b0; cet = 1'b0; up = 1'b1;
    tick();
    checks++;
    if (q !== 4'd12) begin errors++; $display("FAIL oor_load_q: got %0d want 12", q); end
    cet = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL oor_tc: got %0b want 0", tc); end
    pe = 1'b1; cep = 1'b1;
    tick();
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL oor_up_q: got %0d want 0", q); end
    checks++;
    if (co !== 1'b1) begin errors++; $display("FAIL oor_up_co: got %0b want 1", co); end
    pe = 1'b0; d = 4'hD;
    tick();
    pe = 1'b1; up = 1'b0;
    tick();
    checks++;
    if (q !== 4'd9) begin errors++; $display("FAIL oor_dn_q: got %0d want 9", q); end
    checks++;
    if (co !== 1'b1) begin errors++; $display("FAIL oor_dn_co: got %0b want 1", co); end
    tick();
    checks++;
    if (co !== 1'b0 || q !== 4'd8) begin errors++; $display("FAIL oor_after: got q=%0d co=%0b want q=8 co=0", q, co); end
  endtask

  task automatic test_enables();
    pe = 1'b0; d = 4'd5; up = 1'b1;
    tick();
    pe = 1'b1; cep = 1'b1; cet = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd5 || tc !== 1'b0) begin errors++; $display("FAIL hold_cet: got q=%0d tc=%0b want q=5 tc=0", q, tc); end
    pe = 1'b0; d = 4'd9;
    tick();
    pe = 1'b1; cep = 1'b0; cet = 1'b1;
    tick();
    checks++;
    if (q !== 4'd9 || tc !== 1'b1) begin errors++; $display("FAIL hold_cep: got q=%0d tc=%0b want q=9 tc=1", q, tc); end
    checks++;
    if (co !== 1'b0) begin errors++; $display("FAIL hold_co: got %0b want 0", co); end
  endtask

  task automatic test_mr_priority();
    mr = 1'b0; pe = 1'b1; cep = 1'b1; cet = 1'b1; up = 1'b1;
    tick();
    tick();
    mr = 1'b1; pe = 1'b0; d = 4'd7;
    tick();
    checks++;
    if (q !== 4'd0 || co !== 1'b0) begin errors++; $display("FAIL mr_prio: got q=%0d co=%0b want q=0 co=0", q, co); end
    mr = 1'b0; pe = 1'b1;
    tick();
    checks++;
    if (q !== 4'd1) begin errors++; $display("FAIL mr_resume: got %0d want 1", q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mr  = ($urandom_range(0, 24) == 0);
      pe  = ($urandom_range(0, 7) != 0);
      cep = ($urandom_range(0, 4) != 0);
      cet = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      d   = W'($urandom_range(0, 15));
      tick();
      checks++;
      if (q !== W'(m_q) || co !== m_co[0] || tc !== exp_tc()) begin
        errors++;
        $display("FAIL random step %0d: got q=%0d co=%0b tc=%0b want q=%0d co=%0d tc=%0d",
                 i, q, co, tc, m_q, m_co, exp_tc());
      end
    end
  endtask

  task automatic test_cascade();
    c_mr = 1'b1;
    tick();
    c_mr = 1'b0; c_pe = 1'b1; c_cep = 1'b1; c_cet = 1'b1; c_up = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) begin
        checks++;
        if (q0 !== 8'd255 || q1 !== 8'd0 || tc0 !== 1'b1) begin
          errors++;
          $display("FAIL cascade_255: got q0=%0d q1=%0d tc0=%0b want 255 0 1", q0, q1, tc0);
        end
      end
    end
    checks++;
    if (q0 !== 8'd0 || q1 !== 8'd1) begin errors++; $display("FAIL cascade_256: got q0=%0d q1=%0d want q0=0 q1=1", q0, q1); end
    checks++;
    if (co0 !== 1'b1 || co1 !== 1'b0) begin errors++; $display("FAIL cascade_co: got co0=%0b co1=%0b want 1 0", co0, co1); end
  endtask

  initial begin
    mr = 1'b1; cep = 1'b0; cet = 1'b0; pe = 1'b1; up = 1'b1; d = '0;
    c_mr = 1'b1; c_cep = 1'b0; c_cet = 1'b0; c_pe = 1'b1; c_up = 1'b1; c_d = '0;
    test_reset();
    test_count(1'b1);
    test_count(1'b0);
    test_out_of_range();
    test_enables();
    test_mr_priority();
    test_random();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
